motor_drive_control: RTL and testbench
======================================

Name: motor_drive_control

Overview:
- Consumer end of the 4-bit steering-code interface produced by the line-following direction logic.
- Converts each steering code and the travel-direction flag into per-wheel H-bridge polarity and PWM drive.
- Applies rate-limited duty ramping and a coast dead-time before any wheel polarity reversal, protecting the bridge and drivetrain.
- Sits between the direction logic and the two motor driver channels.

Parameters:
- PWM_DIV, 4, clk cycles per PWM counter increment (PWM period = 256*PWM_DIV cycles).
- RAMP_DIV, 1000, clk cycles between ramp ticks.
- RAMP_STEP, 16, maximum duty change per ramp tick.
- DEAD_CYCLES, 500, coast cycles inserted before a polarity flip.
- DUTY_FULL, 200, outer/straight wheel duty.
- DUTY_VEER, 150, inner wheel duty for veer.
- DUTY_HARD, 80, inner wheel duty for hard turn.
- DUTY_PIVOT, 120, duty of both wheels during a ninety-degree pivot.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- DIR  in  4  steering code: [3:2] side (00 proceed, 10 right, 01 left, 11 stop); [1:0] severity (01 veer, 10 hard, 11 ninety).
- Direction  in  1  1 = forwards, 0 = backwards.
- l_in  out  2  left bridge inputs: 10 forward, 01 reverse, 00 coast.
- r_in  out  2  right bridge inputs, same encoding as l_in.
- l_pwm  out  1  left enable PWM.
- r_pwm  out  1  right enable PWM.
- busy  out  1  high while either wheel is in RAMP_DOWN or DEAD.

Behaviour:
- Reset: all outputs 0. Both wheels: current duty 0, target 0, polarity forward, state RUN. PWM counter, prescaler and ramp timer all 0. Reset mid-ramp or mid-dead-time aborts immediately.
- DIR and Direction are registered once. Targets are decoded from the registered values, one cycle later.
- Target decode, forwards:
  - 00_00 → L=R=DUTY_FULL, forward.
  - 10_01 → L=FULL, R=VEER. 10_10 → L=FULL, R=HARD. 10_11 → L=PIVOT forward, R=PIVOT reverse.
  - 01_xx → mirror of the 10_xx codes.
  - 11_11 and every other code → both targets 0; target polarity keeps its current value.
- Backwards: same duties, every target polarity inverted, no left/right swap.
- Ramp: one shared tick every RAMP_DIV cycles. On a tick, each wheel's current duty moves toward its effective target by min(RAMP_STEP, |difference|). No overshoot, no wrap; duty is held within 0..255.
- Per-wheel FSM:
  - RUN: effective target = decoded target. If the target polarity differs from the applied polarity and current duty is not 0, go to RAMP_DOWN. If they differ and current duty = 0, go to DEAD.
  - RAMP_DOWN: effective target = 0. If the target polarity returns to the applied polarity, go back to RUN with no dead-time. When current duty reaches 0, go to DEAD and load the dead counter with DEAD_CYCLES.
  - DEAD: bridge = 00, duty held at 0. Counter decrements each cycle. At 0, apply the latest target polarity and go to RUN. Target changes during DEAD are tracked, not lost.
- PWM: 8-bit counter advances once per PWM_DIV cycles and wraps 255→0. x_pwm is registered as (counter < current duty), so duty 0 gives a constant low.
- x_in is registered. It is 00 in DEAD, or when current duty = 0 and target = 0. Otherwise it is 10 for applied forward, 01 for applied reverse.
- The two wheels are independent except for the shared PWM counter and ramp tick.
- busy is the OR of the two wheels' (state ≠ RUN).

Test Plan:
- Reset, then DIR=0000, Direction=1. Both duties reach 200 after 13 ramp ticks (~13000 cycles). l_in=r_in=10. l_pwm high 800 of every 1024 cycles.
- From steady PROCEED, DIR=1010 (hard right). Left stays 200. Right ramps down 16 per tick to 80 in 8 ticks, r_in stays 10, busy stays 0.
- From steady PROCEED, DIR=1011. Right ramps to 0, then r_in=00 and busy=1 for exactly 500 cycles. Right then flips to r_in=01 and ramps to 120. Left ramps 200→120.
- During a right RAMP_DOWN, return DIR to 0000. Right returns to RUN with no DEAD phase (r_in never 00) and ramps back up to 200.
- Steady PROCEED, toggle Direction to 0. Both wheels ramp to 0, take 500 dead cycles, then run with l_in=r_in=01 and ramp to 200. DIR=1111 then decays both to 0 with in=00.
- Assert reset mid-DEAD. The next cycle shows all outputs 0, busy=0, and both duties 0.

Source files
------------

// File: rtl/motor_drive_control.sv
// Motor drive control: turns registered steering codes into per-wheel H-bridge polarity and PWM,
// with rate-limited duty ramping and a coast dead-time ahead of every polarity reversal.
module motor_drive_control #(
  parameter int PWM_DIV     = 4,
  parameter int RAMP_DIV    = 1000,
  parameter int RAMP_STEP   = 16,
  parameter int DEAD_CYCLES = 500,
  parameter int DUTY_FULL   = 200,
  parameter int DUTY_VEER   = 150,
  parameter int DUTY_HARD   = 80,
  parameter int DUTY_PIVOT  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] DIR,
  input  logic       Direction,
  output logic [1:0] l_in,
  output logic [1:0] r_in,
  output logic       l_pwm,
  output logic       r_pwm,
  output logic       busy
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd1;
  localparam logic [1:0] ST_DEAD      = 2'd2;

  localparam logic [7:0]  STEP      = 8'(RAMP_STEP);
  localparam logic [7:0]  D_FULL    = 8'(DUTY_FULL);
  localparam logic [7:0]  D_VEER    = 8'(DUTY_VEER);
  localparam logic [7:0]  D_HARD    = 8'(DUTY_HARD);
  localparam logic [7:0]  D_PIVOT   = 8'(DUTY_PIVOT);
  localparam logic [15:0] PWM_LAST  = 16'(PWM_DIV - 1);
  localparam logic [15:0] RAMP_LAST = 16'(RAMP_DIV - 1);
  localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYCLES - 1);

  // Per-wheel FSM state; fwd is the polarity currently applied to the bridge.
  typedef struct packed {
    logic [1:0]  state;
    logic        fwd;
    logic [7:0]  duty;
    logic [15:0] dead;
  } wheel_t;

  localparam wheel_t WHEEL_RESET = '{state: ST_RUN, fwd: 1'b1, duty: 8'd0, dead: 16'd0};

  logic [3:0]  dir_q;
  logic        direction_q;
  logic [7:0]  tgt_duty_q [2];
  logic [7:0]  tgt_duty_d [2];
  logic [1:0]  tgt_fwd_q, tgt_fwd_d;
  logic [15:0] pre_q, pre_d;
  logic [15:0] ramp_q, ramp_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  wheel_t      wheel_q [2];
  wheel_t      wheel_d [2];
  logic [1:0]  in_q [2];
  logic [1:0]  in_d [2];
  logic [1:0]  pwm_q, pwm_d;
  logic        ramp_tick, pwm_tick;
  logic        dec_known, dec_lf, dec_rf;
  logic [7:0]  dec_l, dec_r;

  function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] diff;
    if (cur < tgt) begin
      diff = tgt - cur;
      return cur + ((diff > STEP) ? STEP : diff);
    end else begin
      diff = cur - tgt;
      return cur - ((diff > STEP) ? STEP : diff);
    end
  endfunction

  always_comb begin
    dec_known = 1'b1;
    dec_l     = D_FULL;
    dec_r     = D_FULL;
    dec_lf    = 1'b1;
    dec_rf    = 1'b1;
    case (dir_q)
      4'b0000: dec_known = 1'b1;
      4'b1001: dec_r = D_VEER;
      4'b1010: dec_r = D_HARD;
      4'b1011: begin dec_l = D_PIVOT; dec_r = D_PIVOT; dec_rf = 1'b0; end
      4'b0101: dec_l = D_VEER;
      4'b0110: dec_l = D_HARD;
      4'b0111: begin dec_l = D_PIVOT; dec_r = D_PIVOT; dec_lf = 1'b0; end
      default: begin dec_known = 1'b0; dec_l = 8'd0; dec_r = 8'd0; end
    endcase
    tgt_duty_d[0] = dec_l;
    tgt_duty_d[1] = dec_r;
    // Stop and unused codes leave target polarity alone so they never provoke a reversal.
    tgt_fwd_d = dec_known ? ({dec_rf, dec_lf} ^ {2{~direction_q}}) : tgt_fwd_q;
  end

  always_comb begin
    pwm_tick  = (pre_q == PWM_LAST);
    pre_d     = pwm_tick ? 16'd0 : pre_q + 16'd1;
    pwm_cnt_d = pwm_tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    ramp_tick = (ramp_q == RAMP_LAST);
    ramp_d    = ramp_tick ? 16'd0 : ramp_q + 16'd1;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wheel_d[i] = wheel_q[i];
      case (wheel_q[i].state)
        ST_RUN: begin
          if (tgt_fwd_q[i] != wheel_q[i].fwd) begin
            if (wheel_q[i].duty != 8'd0) begin
              wheel_d[i].state = ST_RAMP_DOWN;
            end else begin
              wheel_d[i].state = ST_DEAD;
              wheel_d[i].dead  = DEAD_LOAD;
            end
          end else if (ramp_tick) begin
            wheel_d[i].duty = ramp_toward(wheel_q[i].duty, tgt_duty_q[i]);
          end
        end
        ST_RAMP_DOWN: begin
          if (tgt_fwd_q[i] == wheel_q[i].fwd) begin
            wheel_d[i].state = ST_RUN;
          end else if (wheel_q[i].duty == 8'd0) begin
            wheel_d[i].state = ST_DEAD;
            wheel_d[i].dead  = DEAD_LOAD;
          end else if (ramp_tick) begin
            wheel_d[i].duty = ramp_toward(wheel_q[i].duty, 8'd0);
          end
        end
        ST_DEAD: begin
          wheel_d[i].duty = 8'd0;
          if (wheel_q[i].dead == 16'd0) begin
            wheel_d[i].fwd   = tgt_fwd_q[i];
            wheel_d[i].state = ST_RUN;
          end else begin
            wheel_d[i].dead = wheel_q[i].dead - 16'd1;
          end
        end
        default: wheel_d[i] = WHEEL_RESET;
      endcase
      if (wheel_q[i].state == ST_DEAD ||
          (wheel_q[i].duty == 8'd0 && tgt_duty_q[i] == 8'd0)) begin
        in_d[i] = 2'b00;
      end else begin
        in_d[i] = wheel_q[i].fwd ? 2'b10 : 2'b01;
      end
      pwm_d[i] = (pwm_cnt_q < wheel_q[i].duty);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q       <= 4'b1111;
      direction_q <= 1'b1;
      tgt_fwd_q   <= 2'b11;
      pre_q       <= 16'd0;
      ramp_q      <= 16'd0;
      pwm_cnt_q   <= 8'd0;
      pwm_q       <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        tgt_duty_q[i] <= 8'd0;
        wheel_q[i]    <= WHEEL_RESET;
        in_q[i]       <= 2'b00;
      end
    end else begin
      dir_q       <= DIR;
      direction_q <= Direction;
      tgt_fwd_q   <= tgt_fwd_d;
      pre_q       <= pre_d;
      ramp_q      <= ramp_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pwm_q       <= pwm_d;
      for (int i = 0; i < 2; i++) begin
        tgt_duty_q[i] <= tgt_duty_d[i];
        wheel_q[i]    <= wheel_d[i];
        in_q[i]       <= in_d[i];
      end
    end
  end

  assign l_in  = in_q[0];
  assign r_in  = in_q[1];
  assign l_pwm = pwm_q[0];
  assign r_pwm = pwm_q[1];
  assign busy  = (wheel_q[0].state != ST_RUN) | (wheel_q[1].state != ST_RUN);

endmodule

// File: tb/tb_motor_drive_control.sv
// Bench for motor_drive_control: measures per-ramp-period PWM duty and bridge codes against
// hand-derived expected sequences, plus dead-time length, busy and reset behaviour.
module tb_motor_drive_control;

  localparam int PWM_DIV     = 1;
  localparam int RAMP_DIV    = 400;
  localparam int DEAD_CYCLES = 40;
  localparam int PWM_PERIOD  = 256 * PWM_DIV;
  localparam int WIN_START   = 100;

  logic       clk;
  logic       reset;
  logic [3:0] DIR;
  logic       Direction;
  logic [1:0] l_in, r_in;
  logic       l_pwm, r_pwm, busy;

  int checks;
  int errors;
  int cyc;
  int lin00_cnt, rin00_cnt, busy_cnt;

  // {l_in, r_in, l_duty, r_duty} for one ramp period
  logic [21:0] exp_q[$];

  motor_drive_control #(
    .PWM_DIV(PWM_DIV), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(16), .DEAD_CYCLES(DEAD_CYCLES),
    .DUTY_FULL(200), .DUTY_VEER(150), .DUTY_HARD(80), .DUTY_PIVOT(120)
  ) dut (
    .clk(clk), .reset(reset), .DIR(DIR), .Direction(Direction),
    .l_in(l_in), .r_in(r_in), .l_pwm(l_pwm), .r_pwm(r_pwm), .busy(busy)
  );

  // clock / reset-aligned cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (l_in == 2'b00) lin00_cnt++;
    if (r_in == 2'b00) rin00_cnt++;
    if (busy) busy_cnt++;
  end

  function automatic int clamp_lo(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

  function automatic int clamp_hi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  task automatic push_exp(input logic [1:0] lin, input logic [1:0] rin, input int ld, input int rd);
    exp_q.push_back({lin, rin, 9'(ld), 9'(rd)});
  endtask

  task automatic clear_counts();
    lin00_cnt = 0;
    rin00_cnt = 0;
    busy_cnt  = 0;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * RAMP_DIV) @(negedge clk);
  endtask

  // Scoreboard consumer: one PWM period in the quiet middle of a ramp period.
  task automatic measure(input string name);
    int guard;
    int l_cnt;
    int r_cnt;
    logic [21:0] got;
    logic [21:0] exp;
    guard = 0;
    while ((cyc % RAMP_DIV) != WIN_START && guard <= RAMP_DIV + 4) begin
      @(negedge clk);
      guard++;
    end
    if (guard > RAMP_DIV + 4) begin
      checks++;
      errors++;
      $display("FAIL %s: window sync timed out after %0d cycles", name, guard);
    end
    l_cnt = 0;
    r_cnt = 0;
    repeat (PWM_PERIOD) begin
      @(negedge clk);
      if (l_pwm) l_cnt++;
      if (r_pwm) r_cnt++;
    end
    got = {l_in, r_in, 9'(l_cnt), 9'(r_cnt)};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry, got l_in=%b r_in=%b l_duty=%0d r_duty=%0d",
               name, l_in, r_in, l_cnt, r_cnt);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got l_in=%b r_in=%b l_duty=%0d r_duty=%0d, expected l_in=%b r_in=%b l_duty=%0d r_duty=%0d",
                 name, got[21:20], got[19:18], got[17:9], got[8:0],
                 exp[21:20], exp[19:18], exp[17:9], exp[8:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    DIR = 4'b0000;
    Direction = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({l_in, r_in} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in: got l_in=%b r_in=%b, expected 00 00", l_in, r_in);
    end
    checks++;
    if ({l_pwm, r_pwm, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pwm_busy: got l_pwm=%b r_pwm=%b busy=%b, expected 0 0 0", l_pwm, r_pwm, busy);
    end
    clear_counts();
    reset = 1'b0;
  endtask

  task automatic test_proceed_ramp();
    for (int k = 0; k <= 13; k++) push_exp(2'b10, 2'b10, clamp_hi(16 * k, 200), clamp_hi(16 * k, 200));
    push_exp(2'b10, 2'b10, 200, 200);
    for (int k = 0; k <= 14; k++) measure("proceed_ramp");
  endtask

  task automatic test_hard_right();
    clear_counts();
    DIR = 4'b1010;
    for (int k = 1; k <= 8; k++) push_exp(2'b10, 2'b10, 200, clamp_lo(200 - 16 * k, 80));
    for (int k = 1; k <= 8; k++) measure("hard_right_down");
    checks++;
    if (busy_cnt !== 0) begin
      errors++;
      $display("FAIL hard_right_busy: busy high for %0d cycles, expected 0", busy_cnt);
    end
    DIR = 4'b0000;
    for (int k = 1; k <= 8; k++) push_exp(2'b10, 2'b10, 200, clamp_hi(80 + 16 * k, 200));
    for (int k = 1; k <= 8; k++) measure("hard_right_recover");
  endtask

  task automatic test_abort_ramp_down();
    clear_counts();
    DIR = 4'b1011;
    for (int k = 1; k <= 3; k++) push_exp(2'b10, 2'b10, 200 - 16 * k, 200 - 16 * k);
    for (int k = 1; k <= 3; k++) measure("abort_down");
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_mid: got busy=%b, expected 1", busy);
    end
    DIR = 4'b0000;
    for (int k = 1; k <= 3; k++) push_exp(2'b10, 2'b10, 152 + 16 * k, 152 + 16 * k);
    for (int k = 1; k <= 3; k++) measure("abort_up");
    checks++;
    if (rin00_cnt !== 0) begin
      errors++;
      $display("FAIL abort_no_dead: r_in was 00 for %0d cycles, expected 0", rin00_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy_end: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_pivot();
    int rd;
    clear_counts();
    DIR = 4'b1011;
    for (int k = 1; k <= 21; k++) begin
      rd = (k <= 13) ? clamp_lo(200 - 16 * k, 0) : clamp_hi(16 * (k - 13), 120);
      push_exp(2'b10, (k < 13) ? 2'b10 : 2'b01, clamp_lo(200 - 16 * k, 120), rd);
    end
    for (int k = 1; k <= 21; k++) measure("pivot_right");
    checks++;
    if (rin00_cnt !== DEAD_CYCLES) begin
      errors++;
      $display("FAIL pivot_dead_len: r_in 00 for %0d cycles, expected %0d", rin00_cnt, DEAD_CYCLES);
    end
    checks++;
    if (lin00_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pivot_left_busy: l_in 00 for %0d cycles busy=%b, expected 0 cycles busy=0", lin00_cnt, busy);
    end
    DIR = 4'b0000;
    wait_ticks(23);
    push_exp(2'b10, 2'b10, 200, 200);
    measure("pivot_settle");
  endtask

  task automatic test_backwards_and_stop();
    int d;
    clear_counts();
    Direction = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      d = (k <= 13) ? clamp_lo(200 - 16 * k, 0) : clamp_hi(16 * (k - 13), 200);
      push_exp((k < 13) ? 2'b10 : 2'b01, (k < 13) ? 2'b10 : 2'b01, d, d);
    end
    for (int k = 1; k <= 26; k++) measure("backwards");
    checks++;
    if (lin00_cnt !== DEAD_CYCLES || rin00_cnt !== DEAD_CYCLES) begin
      errors++;
      $display("FAIL backwards_dead_len: l00=%0d r00=%0d cycles, expected %0d each",
               lin00_cnt, rin00_cnt, DEAD_CYCLES);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL backwards_busy: got busy=%b, expected 0", busy);
    end
    DIR = 4'b1111;
    for (int k = 1; k <= 13; k++) begin
      d = clamp_lo(200 - 16 * k, 0);
      push_exp((d > 0) ? 2'b01 : 2'b00, (d > 0) ? 2'b01 : 2'b00, d, d);
    end
    for (int k = 1; k <= 13; k++) measure("stop_decay");
  endtask

  task automatic test_reset_mid_dead();
    int n;
    int hi;
    DIR = 4'b0000;
    Direction = 1'b1;
    n = $urandom_range(6, 30);
    repeat (n) @(negedge clk);
    checks++;
    if ({busy, l_in, r_in} !== 5'b1_00_00) begin
      errors++;
      $display("FAIL mid_dead_state: got busy=%b l_in=%b r_in=%b, expected 1 00 00", busy, l_in, r_in);
    end
    DIR = 4'b1111;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({l_in, r_in, l_pwm, r_pwm, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_abort_dead: got l_in=%b r_in=%b l_pwm=%b r_pwm=%b busy=%b, expected all 0",
               l_in, r_in, l_pwm, r_pwm, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    hi = 0;
    repeat (PWM_PERIOD + 4) begin
      @(negedge clk);
      if (l_pwm || r_pwm || busy || l_in != 2'b00 || r_in != 2'b00) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: %0d active cycles, expected 0", hi);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_counts();
    test_reset();
    test_proceed_ramp();
    test_hard_right();
    test_abort_ramp_down();
    test_pivot();
    test_backwards_and_stop();
    test_reset_mid_dead();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
